// File: rtl/uart_tx_stdout_pkg.sv
// Shared constants and types for the memory-mapped 8N1 UART transmitter.
package uart_tx_stdout_pkg;

  localparam logic [63:0] UART_BASE   = 64'h0000_0000_0000_0400;
  localparam logic [63:0] UART_WINDOW = 64'h18;

  localparam logic [4:0] UART_TXDATA = 5'h00;
  localparam logic [4:0] UART_STATUS = 5'h08;
  localparam logic [4:0] UART_CTRL   = 5'h10;

  localparam int unsigned STATUS_FULL      = 0;
  localparam int unsigned STATUS_EMPTY     = 1;
  localparam int unsigned STATUS_BUSY      = 2;
  localparam int unsigned STATUS_OVERFLOW  = 3;
  localparam int unsigned STATUS_COUNT_LSB = 8;

  localparam int unsigned CTRL_IRQ_EN = 0;
  localparam int unsigned CTRL_FLUSH  = 1;

  typedef enum logic [2:0] {
    MemStoreNone   = 3'd0,
    MemStoreByte   = 3'd1,
    MemStoreHalf   = 3'd2,
    MemStoreWord   = 3'd3,
    MemStoreDouble = 3'd4
  } mem_store_type_t;

  typedef enum logic [1:0] {
    UartIdle,
    UartStart,
    UartData,
    UartStop
  } uart_tx_state_t;

endpackage

// File: rtl/uart_tx_stdout_sync_fifo.sv
// Single-clock FIFO with synchronous flush; push while full is accepted only with a same-cycle pop.
module uart_tx_stdout_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16,
  localparam int unsigned PtrW = $clog2(DEPTH),
  localparam int unsigned CntW = $clog2(DEPTH) + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CntW-1:0]  count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             push_ok, pop_ok;

  assign full    = (count_q == CntW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      count_q <= count_q + CntW'(push_ok) - CntW'(pop_ok);
    end
  end

  // Storage needs no reset: nothing is read past the count.
  always_ff @(posedge clock) begin
    if (push_ok && !flush) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/uart_tx_stdout.sv
// Memory-mapped 8N1 UART transmitter: TXDATA/STATUS/CTRL registers, TX FIFO and baud serializer.
module uart_tx_stdout
  import uart_tx_stdout_pkg::*;
#(
  parameter logic [63:0] BASE_ADDR    = 64'h0,
  parameter int unsigned FIFO_DEPTH   = 16,
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [63:0]     addr,
  input  logic [63:0]     w_data,
  input  mem_store_type_t mem_store_type,
  input  logic            valid,
  output logic [63:0]     r_data,
  output logic            uart_taken,
  output logic            tx,
  output logic            tx_irq
);

  localparam int unsigned CntW  = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned BaudW = $clog2(CLKS_PER_BIT);
  localparam logic [BaudW-1:0] BaudReload = BaudW'(CLKS_PER_BIT - 1);

  logic [63:0] offset;
  logic        is_store, wr_en, rd_en;
  logic        txdata_wr, status_rd, ctrl_wr;

  assign offset     = addr - BASE_ADDR;
  assign uart_taken = (offset < UART_WINDOW) && (addr[2:0] == 3'b000);
  assign is_store   = (mem_store_type != MemStoreNone);
  assign wr_en      = valid & uart_taken & is_store;
  assign rd_en      = valid & uart_taken & ~is_store;
  assign txdata_wr  = wr_en && (offset[4:0] == UART_TXDATA);
  assign ctrl_wr    = wr_en && (offset[4:0] == UART_CTRL);
  assign status_rd  = rd_en && (offset[4:0] == UART_STATUS);

  logic            fifo_pop, fifo_flush, fifo_full, fifo_empty;
  logic [7:0]      fifo_rdata;
  logic [CntW-1:0] fifo_count;

  assign fifo_flush = ctrl_wr & w_data[CTRL_FLUSH];

  uart_tx_stdout_sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (txdata_wr),
    .pop   (fifo_pop),
    .flush (fifo_flush),
    .wdata (w_data[7:0]),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  uart_tx_state_t   state_q, state_d;
  logic [BaudW-1:0] baud_cnt_q, baud_cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shreg_q, shreg_d;
  logic             tx_q, tx_d;
  logic             tx_irq_q, tx_irq_d;
  logic             irq_en_q, irq_en_d;
  logic             overflow_q, overflow_d;
  logic             baud_done;

  assign baud_done = (baud_cnt_q == '0);

  always_comb begin
    state_d    = state_q;
    baud_cnt_d = baud_cnt_q;
    bit_idx_d  = bit_idx_q;
    shreg_d    = shreg_q;
    fifo_pop   = 1'b0;
    case (state_q)
      UartIdle: begin
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          shreg_d    = fifo_rdata;
          baud_cnt_d = BaudReload;
          state_d    = UartStart;
        end
      end
      UartStart: begin
        if (baud_done) begin
          state_d    = UartData;
          bit_idx_d  = 3'd0;
          baud_cnt_d = BaudReload;
        end else begin
          baud_cnt_d = baud_cnt_q - BaudW'(1);
        end
      end
      UartData: begin
        if (baud_done) begin
          shreg_d    = {1'b0, shreg_q[7:1]};
          baud_cnt_d = BaudReload;
          if (bit_idx_q == 3'd7) state_d = UartStop;
          else                   bit_idx_d = bit_idx_q + 3'd1;
        end else begin
          baud_cnt_d = baud_cnt_q - BaudW'(1);
        end
      end
      UartStop: begin
        if (baud_done) begin
          // Chain straight into the next start bit when more data is queued.
          if (!fifo_empty) begin
            fifo_pop   = 1'b1;
            shreg_d    = fifo_rdata;
            baud_cnt_d = BaudReload;
            state_d    = UartStart;
          end else begin
            state_d = UartIdle;
          end
        end else begin
          baud_cnt_d = baud_cnt_q - BaudW'(1);
        end
      end
      default: state_d = UartIdle;
    endcase
  end

  // The line is registered from the next state so it changes on the same edge as the FSM.
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      UartStart: tx_d = 1'b0;
      UartData:  tx_d = shreg_d[0];
      default:   tx_d = 1'b1;
    endcase
  end

  assign tx_irq_d   = irq_en_q & fifo_empty & (state_q == UartIdle);
  assign irq_en_d   = ctrl_wr ? w_data[CTRL_IRQ_EN] : irq_en_q;
  assign overflow_d = (txdata_wr & fifo_full & ~fifo_pop) | (overflow_q & ~status_rd);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= UartIdle;
      baud_cnt_q <= '0;
      bit_idx_q  <= '0;
      shreg_q    <= '0;
      tx_q       <= 1'b1;
      tx_irq_q   <= 1'b0;
      irq_en_q   <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_cnt_q <= baud_cnt_d;
      bit_idx_q  <= bit_idx_d;
      shreg_q    <= shreg_d;
      tx_q       <= tx_d;
      tx_irq_q   <= tx_irq_d;
      irq_en_q   <= irq_en_d;
      overflow_q <= overflow_d;
    end
  end

  assign tx     = tx_q;
  assign tx_irq = tx_irq_q;

  always_comb begin
    r_data = '0;
    if (rd_en) begin
      if (offset[4:0] == UART_STATUS) begin
        r_data[STATUS_FULL]                  = fifo_full;
        r_data[STATUS_EMPTY]                 = fifo_empty;
        r_data[STATUS_BUSY]                  = (state_q != UartIdle);
        r_data[STATUS_OVERFLOW]              = overflow_q;
        r_data[STATUS_COUNT_LSB +: CntW]     = fifo_count;
      end else if (offset[4:0] == UART_CTRL) begin
        r_data[CTRL_IRQ_EN] = irq_en_q;
      end
    end
  end

  logic unused_wdata;
  assign unused_wdata = ^w_data[63:8];

endmodule
